fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller.
// Issues one word request at a time, buffers the returned instruction for
// decode, and handles redirects, traps, misaligned targets and hazard stalls.
//
// Handshake: a request is outstanding while o_imem_req is 1. o_imem_addr stays
// stable until i_imem_ack. An ack is honoured only while o_imem_req is 1 or
// while the FSM is draining a cancelled request. Any other ack is ignored.
// On the decode side, o_fetch_valid marks a buffered instruction. That
// instruction is consumed in the first cycle where decode is not stalled and
// no redirect or trap is present.

`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif
`ifndef NO_E
`define NO_E 4'hf
`endif

module fetch_ctrl #(
  parameter int                         XLEN     = `XLEN_64b,
  parameter logic [(1<<(XLEN+4))-1:0]   RESET_PC = '0
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_stall_d,
  input  logic                        i_redirect,
  input  logic [(1<<(XLEN+4))-1:0]    i_redirect_pc,
  input  logic                        i_trap,
  input  logic [(1<<(XLEN+4))-1:0]    i_trap_pc,
  input  logic                        i_imem_ack,
  input  logic [31:0]                 i_imem_rdata,
  output logic                        o_imem_req,
  output logic [(1<<(XLEN+4))-1:0]    o_imem_addr,
  output logic [31:0]                 o_instr_f,
  output logic [(1<<(XLEN+4))-1:0]    o_pc_f,
  output logic [(1<<(XLEN+4))-1:0]    o_pc_p4_f,
  output logic [3:0]                  o_exception_code_f,
  output logic                        o_if_id_stall,
  output logic                        o_if_id_flush,
  output logic                        o_exception_f_stall,
  output logic                        o_fetch_valid
);

  localparam int          W              = 1 << (XLEN + 4);
  localparam logic [31:0] NOP_INSTR      = 32'h00000013;
  localparam logic [3:0]  EXC_MISALIGNED = 4'd0;
  localparam logic [3:0]  EXC_NONE       = `NO_E;
  localparam logic [W-1:0] PC_STEP       = W'(4);

  // FETCH    : request the word at r_pc (or flag it when misaligned)
  // HOLD     : fetch buffer full, waiting for decode to consume it
  // DRAIN    : a cancelled request is still in flight; discard its ack
  // EXC_WAIT : a faulting instruction was consumed; wait for trap entry
  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    HOLD     = 2'd1,
    DRAIN    = 2'd2,
    EXC_WAIT = 2'd3
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_pc;
  logic [31:0]  r_instr;
  logic [W-1:0] r_pc_f;
  logic [W-1:0] r_pc_p4;
  logic [3:0]   r_code;
  logic         r_valid;

  logic         w_pc_aligned;
  logic         w_req;
  logic         w_ack;
  logic         w_ctrl;
  logic [W-1:0] w_target;
  logic         w_consume;

  // Request, redirect and consume decode. These depend only on registers and
  // the current-cycle control inputs.
  always_comb begin
    w_pc_aligned = (r_pc[1:0] == 2'b00);
    w_req        = (r_state == FETCH) && w_pc_aligned;
    w_ack        = i_imem_ack && (w_req || (r_state == DRAIN));
    w_ctrl       = i_trap || i_redirect;
    w_target     = i_trap ? i_trap_pc : i_redirect_pc;
    w_consume    = (r_state == HOLD) && !i_stall_d && !w_ctrl;
  end

  // Main fetch FSM, PC register and fetch buffer.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_pc_f  <= '0;
      r_pc_p4 <= '0;
      r_code  <= EXC_NONE;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_ctrl) begin
            // A request that is still waiting for its ack must be drained
            // before the new target can be requested.
            r_pc    <= w_target;
            r_valid <= 1'b0;
            if (w_req && !i_imem_ack) begin
              r_state <= DRAIN;
            end else begin
              r_state <= FETCH;
            end
          end else if (!w_pc_aligned) begin
            // Misaligned target: hand a NOP to decode, tagged with the
            // misaligned-fetch code, without touching memory.
            r_instr <= NOP_INSTR;
            r_pc_f  <= r_pc;
            r_pc_p4 <= r_pc + PC_STEP;
            r_code  <= EXC_MISALIGNED;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end else if (w_ack) begin
            r_instr <= i_imem_rdata;
            r_pc_f  <= r_pc;
            r_pc_p4 <= r_pc + PC_STEP;
            r_code  <= EXC_NONE;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end
        end

        HOLD: begin
          if (w_ctrl) begin
            r_pc    <= w_target;
            r_valid <= 1'b0;
            r_state <= FETCH;
          end else if (w_consume) begin
            r_valid <= 1'b0;
            if (r_code != EXC_NONE) begin
              // Fetch stops here until the trap handler address arrives.
              r_state <= EXC_WAIT;
            end else begin
              r_pc    <= r_pc + PC_STEP;
              r_state <= FETCH;
            end
          end
        end

        DRAIN: begin
          if (w_ctrl) begin
            r_pc    <= w_target;
            r_valid <= 1'b0;
          end
          // The data of the cancelled request is dropped.
          if (i_imem_ack) begin
            r_state <= FETCH;
          end
        end

        EXC_WAIT: begin
          // Redirects cannot leave this state; only trap entry can.
          if (i_trap) begin
            r_pc    <= i_trap_pc;
            r_valid <= 1'b0;
            r_state <= FETCH;
          end
        end

        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  // Output mapping.
  always_comb begin
    o_imem_req          = w_req;
    o_imem_addr         = r_pc;
    o_instr_f           = r_instr;
    o_pc_f              = r_pc_f;
    o_pc_p4_f           = r_pc_p4;
    o_exception_code_f  = r_code;
    o_fetch_valid       = r_valid;
    o_exception_f_stall = (r_state == EXC_WAIT);
    o_if_id_stall       = i_stall_d;
    // An empty buffer that decode is not stalled on becomes a bubble.
    o_if_id_flush       = i_trap || i_redirect || (!r_valid && !i_stall_d);
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios followed by a randomized fetch stream.
// The reference model treats the fetch stream as a sequence of addresses
// (sequential +4, or jump to a redirect target) and a buffered instruction.

`ifndef XLEN_64b
`define XLEN_64b 2
`endif
`ifndef NO_E
`define NO_E 4'hf
`endif

module tb_fetch_ctrl;
  localparam int W = 64;
  localparam logic [3:0] NO_E_CODE = `NO_E;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          stall_d;
  logic          redirect;
  logic [W-1:0]  redirect_pc;
  logic          trap;
  logic [W-1:0]  trap_pc;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          imem_req;
  logic [W-1:0]  imem_addr;
  logic [31:0]   instr_f;
  logic [W-1:0]  pc_f;
  logic [W-1:0]  pc_p4_f;
  logic [3:0]    exc_code_f;
  logic          if_id_stall;
  logic          if_id_flush;
  logic          exc_f_stall;
  logic          fetch_valid;

  fetch_ctrl #(
    .XLEN     (`XLEN_64b),
    .RESET_PC ('0)
  ) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_stall_d           (stall_d),
    .i_redirect          (redirect),
    .i_redirect_pc       (redirect_pc),
    .i_trap              (trap),
    .i_trap_pc           (trap_pc),
    .i_imem_ack          (imem_ack),
    .i_imem_rdata        (imem_rdata),
    .o_imem_req          (imem_req),
    .o_imem_addr         (imem_addr),
    .o_instr_f           (instr_f),
    .o_pc_f              (pc_f),
    .o_pc_p4_f           (pc_p4_f),
    .o_exception_code_f  (exc_code_f),
    .o_if_id_stall       (if_id_stall),
    .o_if_id_flush       (if_id_flush),
    .o_exception_f_stall (exc_f_stall),
    .o_fetch_valid       (fetch_valid)
  );

  // Scoreboard state
  int            checks   = 0;
  int            failures = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_pc;
  logic [31:0]   exp_instr;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge, outputs
  // are sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic ack_word(input logic [31:0] w);
    imem_ack   = 1'b1;
    imem_rdata = w;
    cyc();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    settle();
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!imem_req && n < budget) begin
      cyc();
      n++;
    end
    chk("req_within_budget", W'(imem_req), W'(1));
  endtask

  task automatic check_next_addr(input string tag);
    logic [W-1:0] a;
    a = exp_q.pop_front();
    chk(tag, imem_addr, a);
  endtask

  // Global time limit
  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [W-1:0] tgt;
    int kind;
    int lat;

    rst_n       = 1'b0;
    stall_d     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    trap        = 1'b0;
    trap_pc     = '0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;

    // Reset state
    cyc();
    cyc();
    chk("rst_valid", W'(fetch_valid), W'(0));
    chk("rst_instr", W'(instr_f), W'(0));
    chk("rst_pc_f", pc_f, W'(0));
    chk("rst_pc_p4", pc_p4_f, W'(0));
    chk("rst_code", W'(exc_code_f), W'(NO_E_CODE));

    // First fetch: request right after release, ack after 3 cycles
    rst_n = 1'b1;
    settle();
    chk("boot_req", W'(imem_req), W'(1));
    chk("boot_addr", imem_addr, W'(0));
    chk("boot_flush", W'(if_id_flush), W'(1));
    repeat (3) begin
      cyc();
      chk("boot_req_wait", W'(imem_req), W'(1));
      chk("boot_addr_stable", imem_addr, W'(0));
    end
    ack_word(32'h00500093);
    chk("f0_instr", W'(instr_f), W'(32'h00500093));
    chk("f0_pc", pc_f, W'(0));
    chk("f0_pc_p4", pc_p4_f, W'(4));
    chk("f0_valid", W'(fetch_valid), W'(1));
    chk("f0_code", W'(exc_code_f), W'(NO_E_CODE));
    chk("f0_no_req", W'(imem_req), W'(0));
    cyc();
    chk("f1_req", W'(imem_req), W'(1));
    chk("f1_addr", imem_addr, W'(4));
    chk("f1_empty", W'(fetch_valid), W'(0));

    // Decode stall holds the buffer
    w = 32'h00a00113;
    ack_word(w);
    stall_d = 1'b1;
    repeat (4) begin
      cyc();
      chk("stall_instr", W'(instr_f), W'(w));
      chk("stall_pc", pc_f, W'(4));
      chk("stall_valid", W'(fetch_valid), W'(1));
      chk("stall_out", W'(if_id_stall), W'(1));
      chk("stall_no_req", W'(imem_req), W'(0));
      chk("stall_no_flush", W'(if_id_flush), W'(0));
    end
    stall_d = 1'b0;
    settle();
    chk("unstall_out", W'(if_id_stall), W'(0));
    cyc();
    chk("unstall_req", W'(imem_req), W'(1));
    chk("unstall_addr", imem_addr, W'(8));

    // Redirect with a request outstanding: late ack is dropped
    redirect    = 1'b1;
    redirect_pc = W'(32'h100);
    settle();
    chk("redir_flush", W'(if_id_flush), W'(1));
    cyc();
    redirect = 1'b0;
    settle();
    chk("drain_no_req", W'(imem_req), W'(0));
    cyc();
    chk("drain_no_req2", W'(imem_req), W'(0));
    ack_word(32'hdeadbeef);
    chk("drain_discard_valid", W'(fetch_valid), W'(0));
    chk("drain_discard_instr", W'(instr_f), W'(w));
    chk("drain_req", W'(imem_req), W'(1));
    chk("drain_addr", imem_addr, W'(32'h100));
    ack_word(32'h00000033);
    chk("t100_pc", pc_f, W'(32'h100));

    // Misaligned redirect, then exception wait until trap entry
    redirect    = 1'b1;
    redirect_pc = W'(32'h102);
    cyc();
    redirect = 1'b0;
    settle();
    chk("mis_no_req", W'(imem_req), W'(0));
    cyc();
    chk("mis_instr", W'(instr_f), W'(32'h00000013));
    chk("mis_code", W'(exc_code_f), W'(0));
    chk("mis_valid", W'(fetch_valid), W'(1));
    chk("mis_pc", pc_f, W'(32'h102));
    cyc();
    chk("excw_stall", W'(exc_f_stall), W'(1));
    chk("excw_no_req", W'(imem_req), W'(0));
    redirect    = 1'b1;
    redirect_pc = W'(32'h300);
    cyc();
    redirect = 1'b0;
    settle();
    chk("excw_redir_ignored", W'(exc_f_stall), W'(1));
    chk("excw_redir_no_req", W'(imem_req), W'(0));
    trap    = 1'b1;
    trap_pc = W'(32'h200);
    cyc();
    trap = 1'b0;
    settle();
    chk("trap_exit", W'(exc_f_stall), W'(0));
    chk("trap_req", W'(imem_req), W'(1));
    chk("trap_addr", imem_addr, W'(32'h200));

    // Trap beats redirect in the same cycle (ack arriving with them)
    trap        = 1'b1;
    trap_pc     = W'(32'h80);
    redirect    = 1'b1;
    redirect_pc = W'(32'h40);
    imem_ack    = 1'b1;
    imem_rdata  = 32'h11111111;
    cyc();
    trap     = 1'b0;
    redirect = 1'b0;
    imem_ack = 1'b0;
    settle();
    chk("prio_req", W'(imem_req), W'(1));
    chk("prio_addr", imem_addr, W'(32'h80));
    chk("prio_valid", W'(fetch_valid), W'(0));

    // Reset in HOLD
    ack_word(32'h22222222);
    chk("pre_rst_valid", W'(fetch_valid), W'(1));
    stall_d = 1'b1;
    rst_n   = 1'b0;
    cyc();
    chk("midrst_valid", W'(fetch_valid), W'(0));
    chk("midrst_instr", W'(instr_f), W'(0));
    rst_n   = 1'b1;
    stall_d = 1'b0;
    settle();
    chk("midrst_req", W'(imem_req), W'(1));
    chk("midrst_addr", imem_addr, W'(0));

    // Randomized fetch stream against the address-sequence model
    exp_pc = '0;
    exp_q.push_back(exp_pc);
    for (int it = 0; it < 40; it++) begin
      wait_req(4);
      check_next_addr("rnd_addr");
      kind = $urandom_range(0, 4);
      lat  = $urandom_range(0, 3);
      repeat (lat) begin
        cyc();
        chk("rnd_req_hold", W'(imem_req), W'(1));
        chk("rnd_addr_stable", imem_addr, exp_pc);
      end
      if (kind == 0) begin
        tgt         = W'($urandom_range(0, 32'hffff)) << 2;
        redirect    = 1'b1;
        redirect_pc = tgt;
        cyc();
        redirect = 1'b0;
        settle();
        chk("rnd_drain_no_req", W'(imem_req), W'(0));
        repeat ($urandom_range(0, 2)) cyc();
        ack_word($urandom);
        chk("rnd_drain_valid", W'(fetch_valid), W'(0));
        exp_pc = tgt;
        exp_q.push_back(exp_pc);
      end else begin
        exp_instr = $urandom;
        ack_word(exp_instr);
        chk("rnd_instr", W'(instr_f), W'(exp_instr));
        chk("rnd_pc", pc_f, exp_pc);
        chk("rnd_pc_p4", pc_p4_f, exp_pc + W'(4));
        chk("rnd_valid", W'(fetch_valid), W'(1));
        chk("rnd_code", W'(exc_code_f), W'(NO_E_CODE));
        stall_d = 1'b1;
        repeat ($urandom_range(0, 2)) begin
          cyc();
          chk("rnd_stall_instr", W'(instr_f), W'(exp_instr));
          chk("rnd_stall_no_req", W'(imem_req), W'(0));
        end
        stall_d = 1'b0;
        if (kind == 1) begin
          tgt         = W'($urandom_range(0, 32'hffff)) << 2;
          redirect    = 1'b1;
          redirect_pc = tgt;
          cyc();
          redirect = 1'b0;
          settle();
          exp_pc = tgt;
        end else begin
          cyc();
          exp_pc = exp_pc + W'(4);
        end
        chk("rnd_consumed", W'(fetch_valid), W'(0));
        chk("rnd_next_req", W'(imem_req), W'(1));
        exp_q.push_back(exp_pc);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
